// File: rtl/hour_count_cfg.sv
// Hour counter 0..23 with up/down count, range-checked preset and a day-rollover pulse.
// Display is BCD tens/units plus AM/PM, in 12 h or 24 h form chosen at run time.
module hour_count_cfg #(
   parameter int DIG_W  = 8,
   parameter int RST_HR = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enb,
   input  logic             dn,
   input  logic             mode24,
   input  logic             ld,
   input  logic [4:0]       ld_hr,
   output logic [DIG_W-1:0] h0,
   output logic [DIG_W-1:0] h1,
   output logic             am_pm,
   output logic             roll,
   output logic             ld_err
);

   logic [4:0]       r_hr;
   logic [4:0]       w_hr_n;
   logic             w_roll;
   logic             w_err;
   logic [4:0]       w_mod12;
   logic [4:0]       w_disp;
   logic [1:0]       w_tens;
   logic [4:0]       w_units;
   logic [DIG_W-1:0] w_h1_ext;
   logic [DIG_W-1:0] w_h0_ext;

   // Next-state selection: reset, then load, then count, then hold.
   always_comb begin
      w_hr_n = r_hr;
      w_roll = 1'b0;
      w_err  = 1'b0;
      if (ld) begin
         if (ld_hr <= 5'd23) w_hr_n = ld_hr;
         else                w_err  = 1'b1;
      end else if (enb) begin
         if (dn) begin
            if (r_hr == 5'd0) begin
               w_hr_n = 5'd23;
               w_roll = 1'b1;
            end else begin
               w_hr_n = r_hr - 5'd1;
            end
         end else begin
            if (r_hr >= 5'd23) begin
               w_hr_n = 5'd0;
               w_roll = 1'b1;
            end else begin
               w_hr_n = r_hr + 5'd1;
            end
         end
      end
      if (!rst) begin
         w_hr_n = 5'(RST_HR);
         w_roll = 1'b0;
         w_err  = 1'b0;
      end
   end

   // Display is derived from the next hour so outputs land on the same edge as r_hr.
   always_comb begin
      w_mod12 = (w_hr_n >= 5'd12) ? (w_hr_n - 5'd12) : w_hr_n;
      if (mode24)                w_disp = w_hr_n;
      else if (w_mod12 == 5'd0)  w_disp = 5'd12;
      else                       w_disp = w_mod12;
      if (w_disp >= 5'd20)       w_tens = 2'd2;
      else if (w_disp >= 5'd10)  w_tens = 2'd1;
      else                       w_tens = 2'd0;
      w_units = w_disp - (5'd10 * {3'b000, w_tens});
      w_h1_ext = '0;
      w_h0_ext = '0;
      w_h1_ext[1:0] = w_tens;
      w_h0_ext[3:0] = w_units[3:0];
   end

   always_ff @(posedge clk) begin
      r_hr   <= w_hr_n;
      h1     <= w_h1_ext;
      h0     <= w_h0_ext;
      am_pm  <= (w_hr_n >= 5'd12);
      roll   <= w_roll;
      ld_err <= w_err;
   end

endmodule

// File: tb/tb_hour_count_cfg.sv
// Directed-vector bench for hour_count_cfg: driver queues expected outputs, monitor checks them.
module tb_hour_count_cfg;

   logic       clk = 1'b0;
   logic       rst, enb, dn, mode24, ld;
   logic [4:0] ld_hr;
   logic [7:0] h0, h1;
   logic       am_pm, roll, ld_err;

   typedef struct {
      logic [7:0] h1;
      logic [7:0] h0;
      logic       ap;
      logic       roll;
      logic       err;
      string      name;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   // 12 h display value after each of the 24 up ticks from 12 AM
   int   seq12 [24] = '{1,2,3,4,5,6,7,8,9,10,11,12,1,2,3,4,5,6,7,8,9,10,11,12};

   hour_count_cfg #(.DIG_W(8), .RST_HR(0)) dut (
      .clk(clk), .rst(rst), .enb(enb), .dn(dn), .mode24(mode24), .ld(ld),
      .ld_hr(ld_hr), .h0(h0), .h1(h1), .am_pm(am_pm), .roll(roll), .ld_err(ld_err)
   );

   always #5 clk = ~clk;

   task automatic step(input logic r, input logic l, input logic [4:0] lh,
                       input logic e, input logic d, input logic m,
                       input int t, input int u, input logic ap,
                       input logic rl, input logic er, input string nm);
      exp_t x;
      @(negedge clk);
      rst = r; ld = l; ld_hr = lh; enb = e; dn = d; mode24 = m;
      x.h1 = 8'(t); x.h0 = 8'(u); x.ap = ap; x.roll = rl; x.err = er; x.name = nm;
      q.push_back(x);
   endtask

   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         exp_t x;
         x = q.pop_front();
         n_vec++;
         if (h1 !== x.h1 || h0 !== x.h0 || am_pm !== x.ap || roll !== x.roll || ld_err !== x.err) begin
            n_bad++;
            $display("FAIL %s: got h1=%0d h0=%0d am_pm=%b roll=%b ld_err=%b, want h1=%0d h0=%0d am_pm=%b roll=%b ld_err=%b",
                     x.name, h1, h0, am_pm, roll, ld_err, x.h1, x.h0, x.ap, x.roll, x.err);
         end
      end
   end

   initial begin
      rst = 1'b0; ld = 1'b0; ld_hr = 5'd0; enb = 1'b0; dn = 1'b0; mode24 = 1'b0;

      // reset into 12 h, then 24 up ticks around the day
      step(0,0,0, 1,0,0, 1,2,0,0,0, "reset12");
      for (int k = 1; k <= 24; k++)
         step(1,0,0, 1,0,0, seq12[k-1]/10, seq12[k-1]%10, (k >= 12 && k <= 23),
              (k == 24), 0, $sformatf("up12_%0d", k));

      // 24 h down-count across midnight
      step(1,1,5'd1, 0,0,1, 0,1,0,0,0, "ld1");
      step(1,0,0, 1,1,1, 0,0,0,0,0, "dn00");
      step(1,0,0, 1,1,1, 2,3,1,1,0, "dn23");
      step(1,0,0, 1,1,1, 2,2,1,0,0, "dn22");

      // load beats enb; out-of-range load holds and flags
      step(1,1,5'd17, 1,0,1, 1,7,1,0,0, "ld17");
      step(1,0,0, 0,0,0, 0,5,1,0,0, "17as5pm");
      step(1,1,5'd30, 1,0,0, 0,5,1,0,1, "ld30err");
      step(1,0,0, 0,0,1, 1,7,1,0,0, "errclr");
      step(1,1,5'd24, 1,1,1, 1,7,1,0,1, "ld24err");
      step(1,1,5'd23, 0,0,1, 2,3,1,0,0, "ld23ok");

      // mode switching at hour 0
      step(1,1,5'd0, 0,0,1, 0,0,0,0,0, "ld0");
      step(1,0,0, 0,0,0, 1,2,0,0,0, "mode12");
      step(1,0,0, 0,0,1, 0,0,0,0,0, "mode24");

      // back-to-back wraps each pulse roll
      step(1,0,0, 1,1,1, 2,3,1,1,0, "wrapdn");
      step(1,0,0, 1,0,1, 0,0,0,1,0, "wrapup");

      // reset mid-count overrides load and enb
      step(1,1,5'd23, 0,0,1, 2,3,1,0,0, "ld23");
      step(0,1,5'd5, 1,0,1, 0,0,0,0,0, "rstmid");
      step(1,0,0, 1,0,1, 0,1,0,0,0, "after_rst");

      @(negedge clk);
      enb = 1'b0; ld = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d vectors left unchecked, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
